// File: rtl/ctrl_pipe_stage.sv
// Parameterised pipeline register for the decoded control bundle, with bubble gating,
// stall/flush handling and an optional bubble counter (macro CTRL_PIPE_BUBBLE_CNT_EN).
module ctrl_pipe_stage #(
    parameter int                CTRL_W    = 9,
    parameter int                DEPTH     = 1,
    parameter logic [CTRL_W-1:0] NOP_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              valid_o
`ifdef CTRL_PIPE_BUBBLE_CNT_EN
    ,
    output logic [15:0]       bubble_cnt_o
`endif
);

    if (DEPTH < 1 || DEPTH > 4 || CTRL_W < 1 || CTRL_W > 64) begin : g_param_err
        $error("ctrl_pipe_stage: DEPTH must be 1..4 and CTRL_W 1..64");
    end

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : gen_stage
        logic [CTRL_W-1:0] ctrl_reg;
        logic              valid_reg;
        logic [CTRL_W-1:0] ctrl_next;
        logic              valid_next;

        if (gi == 0) begin : g_head
            // Invalid slots always carry NOP_VALUE so stale decode data never leaks downstream.
            assign valid_next = valid_i;
            assign ctrl_next  = valid_i ? ctrl_i : NOP_VALUE;
        end else begin : g_body
            assign valid_next = gen_stage[gi-1].valid_reg;
            assign ctrl_next  = gen_stage[gi-1].ctrl_reg;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_reg <= 1'b0;
                ctrl_reg  <= NOP_VALUE;
            end else if (flush_i) begin
                valid_reg <= 1'b0;
                ctrl_reg  <= NOP_VALUE;
            end else if (!stall_i) begin
                valid_reg <= valid_next;
                ctrl_reg  <= ctrl_next;
            end
        end
    end

    assign ctrl_o  = gen_stage[DEPTH-1].ctrl_reg;
    assign valid_o = gen_stage[DEPTH-1].valid_reg;

`ifdef CTRL_PIPE_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_reg;
    logic        bubble_evt;

    // A flush counts once even when a stall coincides; stalled idle cycles inject nothing.
    assign bubble_evt = flush_i | (~stall_i & ~valid_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_reg <= 16'h0000;
        end else if (bubble_evt && bubble_cnt_reg != 16'hFFFF) begin
            bubble_cnt_reg <= bubble_cnt_reg + 16'h0001;
        end
    end

    assign bubble_cnt_o = bubble_cnt_reg;
`endif

endmodule

// File: doc/ctrl_pipe_stage.md
CTRL_PIPE_STAGE -- requirements
Module: ctrl_pipe_stage

Interface
REQ-001 Parameter CTRL_W, default 9, SHALL set the width of the control bundle carried (RegDst, ALUOp[3:0], ALUSrc, Jump[1:0], J_Jump packed = 9).
REQ-002 Parameter DEPTH, default 1, SHALL set the number of register stages; legal range 1..4.
REQ-003 Parameter NOP_VALUE, default all-zeros of CTRL_W, SHALL set the bundle value driven for bubbles.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ctrl_i  input  CTRL_W  control bundle from decode.
REQ-007 valid_i  input  1  ctrl_i carries a real instruction.
REQ-008 stall_i  input  1  hold all stages unchanged this cycle.
REQ-009 flush_i  input  1  kill all in-flight bundles this cycle.
REQ-010 ctrl_o  output  CTRL_W  bundle at final stage.
REQ-011 valid_o  output  1  final stage holds a real instruction.
REQ-012 bubble_cnt_o  output  16  bubbles injected (present only with macro, REQ-027).

Function
REQ-013 Block SHALL be a DEPTH-entry shift register of {valid, ctrl} pairs; ctrl_o/valid_o SHALL be driven directly from the last entry (registered outputs, no combinational input-to-output path).
REQ-014 Latency SHALL be exactly DEPTH rising edges from capture to ctrl_o, absent stall/flush.
REQ-015 Priority per edge SHALL be: rst > flush_i > stall_i > normal shift.
REQ-016 Normal shift: entry0 <= {valid_i, valid_i ? ctrl_i : NOP_VALUE}; entry k <= entry k-1 for k = 1..DEPTH-1.
REQ-017 Invalid input SHALL be zero-gated: any entry with valid=0 SHALL hold NOP_VALUE, never stale or raw ctrl_i data.
REQ-018 stall_i=1 (flush_i=0): every entry SHALL keep its value; ctrl_i/valid_i SHALL be ignored (not captured later).
REQ-019 flush_i=1: every entry SHALL load {0, NOP_VALUE} on that edge, irrespective of stall_i, valid_i.
REQ-020 flush_i and stall_i simultaneous: flush SHALL win; following edge resumes per inputs.
REQ-021 DEPTH outside 1..4 or CTRL_W outside 1..64 SHALL be an elaboration-time error.

Reset
REQ-022 rst assertion SHALL immediately (no clock edge) set every entry to {0, NOP_VALUE}, so ctrl_o = NOP_VALUE, valid_o = 0.
REQ-023 bubble_cnt_o (when present) SHALL reset asynchronously to 0.
REQ-024 While rst=1, inputs SHALL be ignored; first capture SHALL occur on the first rising edge after rst deasserts.
REQ-025 rst asserted mid-operation SHALL discard all in-flight bundles; none SHALL appear after deassertion.

Configuration
REQ-026 Macro CTRL_PIPE_BUBBLE_CNT_EN SHALL compile in the bubble counter and port bubble_cnt_o.
REQ-027 With macro: counter SHALL increment by 1 on each edge where rst=0 and (flush_i=1, or stall_i=0 and valid_i=0); simultaneous flush and stall counts once; saturate at 16'hFFFF (no wrap).
REQ-028 Without macro: bubble_cnt_o and counter SHALL be absent; all other behaviour identical.

Verification
REQ-029 DEPTH=1, rst pulse, then ctrl_i=9'h1A5, valid_i=1 -> after 1 edge ctrl_o=9'h1A5, valid_o=1; during rst ctrl_o=0, valid_o=0 with no edge.
REQ-030 DEPTH=3, stream A=9'h001, B=9'h002, C=9'h003 valid on consecutive edges -> A appears on ctrl_o at edge 3, B edge 4, C edge 5.
REQ-031 DEPTH=3, A, B in flight, stall_i=1 for 2 edges with ctrl_i=9'h0FF valid -> outputs frozen 2 edges, 9'h0FF never appears, A then B emerge after release.
REQ-032 DEPTH=2, flush_i=1 and stall_i=1 same edge with A, B in flight -> next cycle valid_o=0, ctrl_o=NOP_VALUE; A, B never emerge.
REQ-033 valid_i=0 with ctrl_i=9'h1FF -> ctrl_o=NOP_VALUE (0), valid_o=0 DEPTH edges later.
REQ-034 Macro on: 3 idle edges, 1 flush edge, 2 stalled idle edges -> bubble_cnt_o=4; force 70000 idle edges -> bubble_cnt_o=16'hFFFF held.
